// File: rtl/score_ctrl_if.sv
// Game-event / overlay-digit bundle between the game logic and the score controller.
interface score_ctrl_if;
    logic       frame_tick;
    logic       hit;
    logic       miss;
    logic       start;
    logic [4:0] dig1;
    logic [4:0] dig0;
    logic [4:0] dig;
    logic       serving;
    logic       game_over;

    modport master (
        output frame_tick, hit, miss, start,
        input  dig1, dig0, dig, serving, game_over
    );

    modport slave (
        input  frame_tick, hit, miss, start,
        output dig1, dig0, dig, serving, game_over
    );
endinterface

// File: rtl/score_ctrl.sv
// Score / ball-count controller: BCD working registers, game FSM, and
// frame-tick-latched display registers feeding the text overlay.
module score_ctrl #(
    parameter int unsigned BALLS        = 3,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned MAX_SCORE    = 99
) (
    input  logic         clk,
    input  logic         reset,
    score_ctrl_if.slave  bus
);
    localparam int unsigned BCD_W = 4;
    localparam int unsigned CNT_W = 8;

    localparam logic [BCD_W-1:0] MAX_TENS   = BCD_W'(MAX_SCORE / 10);
    localparam logic [BCD_W-1:0] MAX_ONES   = BCD_W'(MAX_SCORE % 10);
    localparam logic [BCD_W-1:0] BALLS_INIT = BCD_W'(BALLS);
    localparam logic [CNT_W-1:0] SERVE_INIT = CNT_W'(SERVE_FRAMES);

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_SERVE   = 2'd1,
        ST_PLAY    = 2'd2,
        ST_OVER    = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;
    logic [BCD_W-1:0] balls_q, balls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [BCD_W-1:0] dig1_q, dig1_d;
    logic [BCD_W-1:0] dig0_q, dig0_d;
    logic [BCD_W-1:0] dig_q, dig_d;
    logic             serving_q, serving_d;
    logic             over_q, over_d;

    logic at_max;
    assign at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_NEWGAME;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state together with the working-register updates it decides.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        balls_d = balls_q;
        cnt_d   = cnt_q;
        if (bus.start && (state_q != ST_NEWGAME)) begin
            state_d = ST_NEWGAME;
        end else begin
            case (state_q)
                ST_NEWGAME: begin
                    tens_d  = '0;
                    ones_d  = '0;
                    balls_d = BALLS_INIT;
                    cnt_d   = SERVE_INIT;
                    state_d = ST_SERVE;
                end
                ST_SERVE: begin
                    if (bus.frame_tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_PLAY;
                        end
                    end
                end
                ST_PLAY: begin
                    if (bus.hit && !at_max) begin
                        if (ones_q == BCD_W'(9)) begin
                            ones_d = '0;
                            tens_d = tens_q + BCD_W'(1);
                        end else begin
                            ones_d = ones_q + BCD_W'(1);
                        end
                    end
                    if (bus.miss) begin
                        if (balls_q > BCD_W'(1)) begin
                            balls_d = balls_q - BCD_W'(1);
                            cnt_d   = SERVE_INIT;
                            state_d = ST_SERVE;
                        end else begin
                            balls_d = '0;
                            state_d = ST_OVER;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags track the state; display snapshots pre-update working values on frame_tick.
    always_comb begin
        serving_d = (state_d == ST_SERVE);
        over_d    = (state_d == ST_OVER);
        dig1_d    = dig1_q;
        dig0_d    = dig0_q;
        dig_d     = dig_q;
        if (bus.frame_tick) begin
            dig1_d = tens_q;
            dig0_d = ones_q;
            dig_d  = balls_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tens_q    <= '0;
            ones_q    <= '0;
            balls_q   <= BALLS_INIT;
            cnt_q     <= '0;
            dig1_q    <= '0;
            dig0_q    <= '0;
            dig_q     <= BALLS_INIT;
            serving_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            balls_q   <= balls_d;
            cnt_q     <= cnt_d;
            dig1_q    <= dig1_d;
            dig0_q    <= dig0_d;
            dig_q     <= dig_d;
            serving_q <= serving_d;
            over_q    <= over_d;
        end
    end

    assign bus.dig1      = {1'b0, dig1_q};
    assign bus.dig0      = {1'b0, dig0_q};
    assign bus.dig       = {1'b0, dig_q};
    assign bus.serving   = serving_q;
    assign bus.game_over = over_q;
endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: integer-level game model checked every cycle, plus
// directed scenarios with literal expected digits and flags.
module tb_score_ctrl;
    localparam int unsigned BALLS        = 3;
    localparam int unsigned SERVE_FRAMES = 60;
    localparam int unsigned MAX_SCORE    = 99;

    localparam int MD_NEW   = 0;
    localparam int MD_SERVE = 1;
    localparam int MD_PLAY  = 2;
    localparam int MD_OVER  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    score_ctrl_if bus();

    score_ctrl #(
        .BALLS        (BALLS),
        .SERVE_FRAMES (SERVE_FRAMES),
        .MAX_SCORE    (MAX_SCORE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model in plain integers: score 0..MAX_SCORE, balls, frames left to serve.
    int         m_mode  = MD_NEW;
    int         m_score = 0;
    int         m_balls = 0;
    int         m_left  = 0;
    bit         m_valid = 1'b0;
    logic [4:0] e_dig1, e_dig0, e_dig;
    logic       e_serv, e_over;

    always @(posedge clk) begin
        if (reset) begin
            m_mode  = MD_NEW;
            m_score = 0;
            m_balls = BALLS;
            m_left  = 0;
            e_dig1  = 5'd0;
            e_dig0  = 5'd0;
            e_dig   = 5'(BALLS);
            e_serv  = 1'b0;
            e_over  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (bus.frame_tick) begin
                e_dig1 = 5'(m_score / 10);
                e_dig0 = 5'(m_score % 10);
                e_dig  = 5'(m_balls);
            end
            if (bus.start && m_mode != MD_NEW) begin
                m_mode = MD_NEW;
            end else if (m_mode == MD_NEW) begin
                m_score = 0;
                m_balls = BALLS;
                m_left  = SERVE_FRAMES;
                m_mode  = MD_SERVE;
            end else if (m_mode == MD_SERVE) begin
                if (bus.frame_tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = MD_PLAY;
                end
            end else if (m_mode == MD_PLAY) begin
                if (bus.hit && m_score < MAX_SCORE) m_score = m_score + 1;
                if (bus.miss) begin
                    m_balls = m_balls - 1;
                    if (m_balls == 0) begin
                        m_mode = MD_OVER;
                    end else begin
                        m_left = SERVE_FRAMES;
                        m_mode = MD_SERVE;
                    end
                end
            end
            e_serv = (m_mode == MD_SERVE);
            e_over = (m_mode == MD_OVER);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_dig1",      8'(bus.dig1),      8'(e_dig1));
            chk("model_dig0",      8'(bus.dig0),      8'(e_dig0));
            chk("model_dig",       8'(bus.dig),       8'(e_dig));
            chk("model_serving",   8'(bus.serving),   8'(e_serv));
            chk("model_game_over", 8'(bus.game_over), 8'(e_over));
        end
    end

    task automatic cyc(input logic r, input logic ft, input logic h, input logic m, input logic s);
        reset          = r;
        bus.frame_tick = ft;
        bus.hit        = h;
        bus.miss       = m;
        bus.start      = s;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.hit        = 1'b0;
        bus.miss       = 1'b0;
        bus.start      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic tick1();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.hit        = 1'b0;
        bus.miss       = 1'b0;
        bus.start      = 1'b0;

        // Reset and the first full serve delay
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_dig1", 8'(bus.dig1), 8'd0);
        chk("rst_dig0", 8'(bus.dig0), 8'd0);
        chk("rst_dig", 8'(bus.dig), 8'd3);
        chk("rst_serving", 8'(bus.serving), 8'd0);
        chk("rst_over", 8'(bus.game_over), 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("newgame_to_serve", 8'(bus.serving), 8'd1);
        ticks(59);
        chk("serve_59_ticks", 8'(bus.serving), 8'd1);
        ticks(1);
        chk("serve_done", 8'(bus.serving), 8'd0);
        chk("serve_dig", 8'(bus.dig), 8'd3);

        // Display latency and the carry into tens
        hits(10);
        chk("pre_tick_dig1", 8'(bus.dig1), 8'd0);
        chk("pre_tick_dig0", 8'(bus.dig0), 8'd0);
        tick1();
        chk("ten_dig1", 8'(bus.dig1), 8'd1);
        chk("ten_dig0", 8'(bus.dig0), 8'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("coincident_hit_hidden", 8'(bus.dig0), 8'd0);
        tick1();
        chk("eleven_dig1", 8'(bus.dig1), 8'd1);
        chk("eleven_dig0", 8'(bus.dig0), 8'd1);

        // Saturation at 99
        hits(105);
        tick1();
        chk("sat_dig1", 8'(bus.dig1), 8'd9);
        chk("sat_dig0", 8'(bus.dig0), 8'd9);

        // First miss; events during serve are ignored
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("miss1_serving", 8'(bus.serving), 8'd1);
        tick1();
        chk("miss1_dig", 8'(bus.dig), 8'd2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick1();
        chk("serve_ign_dig", 8'(bus.dig), 8'd2);
        chk("serve_ign_dig0", 8'(bus.dig0), 8'd9);
        ticks(56);
        chk("serve2_59", 8'(bus.serving), 8'd1);
        ticks(1);
        chk("serve2_done", 8'(bus.serving), 8'd0);

        // Remaining balls down to game over
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(60);
        chk("miss2_dig", 8'(bus.dig), 8'd1);
        chk("miss2_play", 8'(bus.serving), 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("over_flag", 8'(bus.game_over), 8'd1);
        tick1();
        chk("over_dig", 8'(bus.dig), 8'd0);
        hits(3);
        tick1();
        chk("over_frozen_dig1", 8'(bus.dig1), 8'd9);
        chk("over_frozen_dig0", 8'(bus.dig0), 8'd9);
        chk("over_still", 8'(bus.game_over), 8'd1);

        // Start from OVER
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("start_over_clear", 8'(bus.game_over), 8'd0);
        chk("start_newgame", 8'(bus.serving), 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_serve", 8'(bus.serving), 8'd1);
        tick1();
        chk("new_dig1", 8'(bus.dig1), 8'd0);
        chk("new_dig0", 8'(bus.dig0), 8'd0);
        chk("new_dig", 8'(bus.dig), 8'd3);
        ticks(58);
        chk("new_serve_59", 8'(bus.serving), 8'd1);
        ticks(1);
        chk("new_serve_done", 8'(bus.serving), 8'd0);

        // Hit and miss together at balls=2, score=41
        hits(41);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(60);
        chk("hm_play", 8'(bus.serving), 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("hm_serving", 8'(bus.serving), 8'd1);
        chk("hm_not_over", 8'(bus.game_over), 8'd0);
        tick1();
        chk("hm_dig1", 8'(bus.dig1), 8'd4);
        chk("hm_dig0", 8'(bus.dig0), 8'd2);
        chk("hm_dig", 8'(bus.dig), 8'd1);

        // Start mid-countdown restarts the full serve delay
        ticks(10);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("abort_newgame", 8'(bus.serving), 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_serve", 8'(bus.serving), 8'd1);
        tick1();
        chk("abort_dig1", 8'(bus.dig1), 8'd0);
        chk("abort_dig0", 8'(bus.dig0), 8'd0);
        chk("abort_dig", 8'(bus.dig), 8'd3);
        ticks(58);
        chk("abort_serve_59", 8'(bus.serving), 8'd1);
        ticks(1);
        chk("abort_serve_done", 8'(bus.serving), 8'd0);

        // Reset outranks start
        hits(5);
        tick1();
        chk("pre_rst_dig0", 8'(bus.dig0), 8'd5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_start_dig0", 8'(bus.dig0), 8'd0);
        chk("rst_start_dig1", 8'(bus.dig1), 8'd0);
        chk("rst_start_dig", 8'(bus.dig), 8'd3);
        chk("rst_start_serving", 8'(bus.serving), 8'd0);
        chk("rst_start_over", 8'(bus.game_over), 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_serve", 8'(bus.serving), 8'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
- Game-state controller that owns and sequences the score / ball-count digits shown by the text overlay. Outputs feed the overlay's dig1/dig0/dig inputs.
- Accumulates hit and miss events from the game logic into BCD working registers. Publishes them to tear-free display registers only on the frame tick.
- Runs a small game FSM: new game → serve delay → play → game over.

Parameters:
- BALLS, 3, balls at start of game (1..9).
- SERVE_FRAMES, 60, frames of serve delay after new game or lost ball (1..255).
- MAX_SCORE, 99, score saturation value (BCD range 0..99).

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- hit  in  1  one-cycle pulse, score +1
- miss  in  1  one-cycle pulse, ball lost
- start  in  1  one-cycle pulse, start new game
- dig1  out  5  displayed score tens digit, BCD, bit4 always 0
- dig0  out  5  displayed score ones digit, BCD, bit4 always 0
- dig  out  5  displayed balls remaining, BCD, bit4 always 0
- serving  out  1  high while in SERVE state
- game_over  out  1  high while in OVER state

Behaviour:
- Reset (synchronous, active-high):
  - state=NEWGAME; working score=00; working balls=BALLS; serve counter=0.
  - Outputs: dig1=0, dig0=0, dig=BALLS, serving=0, game_over=0.
- All outputs are registered. Reset has priority over every other input.
- States:
  - NEWGAME: one cycle. Clears score to 00, loads balls=BALLS, loads serve counter=SERVE_FRAMES, goes to SERVE.
  - SERVE: hit and miss are ignored. Each frame_tick decrements the serve counter; a frame_tick with counter==1 goes to PLAY. serving=1.
  - PLAY:
    - hit increments the BCD score: ones wrap 9→0 with carry into tens. Score saturates at MAX_SCORE; a hit at MAX_SCORE leaves it unchanged.
    - miss with balls>1 decrements balls, reloads the serve counter, goes to SERVE.
    - miss with balls==1 sets balls=0, goes to OVER.
    - hit and miss in the same cycle: the score increment is applied, then the miss is processed as above.
  - OVER: hit and miss are ignored. game_over=1. Score and balls are frozen.
  - start from any state except NEWGAME goes to NEWGAME next cycle and aborts any serve countdown. start outranks hit/miss in the same cycle.
- Display update:
  - dig1/dig0/dig load from the working registers only on a cycle with frame_tick=1.
  - The loaded values are the working values before that cycle's hit/miss update. An event coincident with frame_tick is displayed at the next frame_tick.
  - Display latency: event → display = cycles to the next frame_tick strictly after the event cycle, +1.
- serving and game_over follow the state register directly (next cycle after the transition); they do not wait for frame_tick.
- Arithmetic:
  - Score is held as two 4-bit BCD digits; binary increment is not permitted.
  - Balls is 4-bit, never below 0 and never above BALLS.
  - Serve counter is 8-bit and decrements only in SERVE on frame_tick.
- A frame_tick in NEWGAME does no decrement but still updates the display.

Test Plan:
- Reset, then 60 frame_ticks (SERVE_FRAMES=60) → serving=1 for the first 59 ticks, state PLAY after tick 60; dig=3, dig1=0, dig0=0 throughout.
- In PLAY: 10 hits, then frame_tick → dig1=1, dig0=0 appear the cycle after the tick, not earlier. A hit coincident with the next tick shows 11 only after the following tick.
- 105 hits in PLAY, then frame_tick → dig1=9, dig0=9 (saturated). Bit4 of every digit is 0.
- Three misses, each separated by a full serve delay → dig goes 2, 1, 0 at successive ticks; game_over=1 after the third miss. Hits in OVER leave the score unchanged.
- In SERVE: hit and miss pulses → no change to score or balls. Then hit and miss in the same cycle in PLAY with balls=2, score=41 → score 42, balls 1, serving=1.
- start during SERVE mid-countdown and during OVER → NEWGAME then SERVE; score 00 and balls 3 are displayed at the next tick; serve counter restarts from 60. A reset asserted together with start → reset values.
